branch_flow_ctrl: RTL
=====================

# branch_flow_ctrl

Sequencing controller for the ID-stage branch resolver in the 5-stage pipeline. It takes the branch type and the resolved taken flag, gates branch evaluation against load-use hazards and memory freezes, and issues PC redirect, flush and bubble controls to the IF/ID and ID/EX registers. It also keeps saturating branch and taken-branch performance counters. It sits between the ID stage (condition-check output, hazard unit) and the IF-stage PC mux and pipeline registers.

## Interface
- `CNT_W`, 16: width of the performance counters.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `br_type`  in  2  branch type of the instruction in ID: 00 none, 01 BEZ, 10 BNE, 11 JMP.
- `br_taken`  in  1  resolved condition for the instruction in ID; valid whenever `br_type` != 00.
- `br_target`  in  32  branch target address computed in ID.
- `hazard`  in  1  load-use hazard on the instruction in ID, from the hazard unit.
- `mem_ready`  in  1  0 freezes the whole pipeline (memory stall).
- `pc_src`  out  1  1 selects `pc_target` into the PC.
- `pc_target`  out  32  registered branch target.
- `pc_freeze`  out  1  hold the PC.
- `ifid_freeze`  out  1  hold IF/ID.
- `ifid_flush`  out  1  clear IF/ID to a NOP.
- `idex_bubble`  out  1  load a NOP into ID/EX.
- `pipe_freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `br_count`  out  CNT_W  branches evaluated.
- `taken_count`  out  CNT_W  branches taken.

## Operation
- FSM with 2 states: RUN (reset state) and REDIRECT.
- Priority order: `rst` > freeze (`mem_ready`=0) > REDIRECT > hazard > branch evaluation.
- **Freeze** (`mem_ready`=0, any state):
  - `pc_freeze`, `ifid_freeze` and `pipe_freeze` are 1.
  - `pc_src`, `ifid_flush` and `idex_bubble` are 0.
  - State, `pc_target` and counters hold.
- **RUN with `hazard`=1**:
  - `pc_freeze`, `ifid_freeze` and `idex_bubble` are 1.
  - The branch is not evaluated and the counters do not change.
  - State stays RUN.
- **RUN, `hazard`=0, `br_type`!=00** (evaluation event):
  - `br_count` increments by 1.
  - If `br_taken`=1: `taken_count` increments, `pc_target` <= `br_target`, next state is REDIRECT.
  - If `br_taken`=0: state stays RUN.
  - A JMP (11) counts as taken only when `br_taken`=1. The resolver always drives 1 for JMP, and this block does not override it.
- **RUN, `hazard`=0, `br_type`=00**: all control outputs are 0.
- **REDIRECT** (one cycle when not frozen):
  - `pc_src`=1, `ifid_flush`=1, `idex_bubble`=1; the freeze outputs are 0.
  - `hazard` and `br_type` are ignored: the instruction in ID is wrong-path and is not counted.
  - Next state is RUN.
- **Counters**: unsigned, saturate at all-ones; no wrap.
- **Combinational outputs**: all control outputs are combinational from state, `mem_ready` and `hazard`.
- **Registered outputs**: `pc_target` and the counters are registered.

## Timing
- **Reset**: a cycle with `rst`=1 sets state to RUN, `pc_target`=0 and both counters to 0. In that cycle all control outputs are 0 and the `mem_ready` gating is overridden. Mid-REDIRECT reset abandons the redirect.
- **Taken branch**, evaluated at cycle t:
  - REDIRECT is active in cycle t+1; the PC loads the target at the end of t+1.
  - The two wrong-path instructions are squashed in t+1: the one fetched at t by the ID/EX bubble, the one fetched at t+1 by the IF/ID flush.
  - Penalty is 2 cycles. The target instruction is in IF at t+2.
- **Not-taken branch**: 0 penalty.
- **Hazard stall**: lasts exactly as long as `hazard`=1 (in RUN, unfrozen). The branch is evaluated in the first cycle with `hazard`=0.
- **Freeze during REDIRECT**: REDIRECT is extended, and its outputs reassert in the first cycle with `mem_ready`=1.
- **Freeze in the evaluation cycle**: the evaluation is deferred; nothing is counted until `mem_ready`=1.
- **Back-to-back branches**: a branch in ID during REDIRECT is never evaluated. The next branch can be evaluated at t+2.

## Test plan
- **Reset**: assert `rst` for 2 cycles with `mem_ready`=0 and `hazard`=1 -> all control outputs are 0 during reset, `pc_target`=0, counters are 0, state is RUN.
- **Taken BEZ**: `br_type`=01, `br_taken`=1, `br_target`=0x0000_0040 at cycle t ->
  - at t+1: `pc_src`=1, `ifid_flush`=1, `idex_bubble`=1, `pc_target`=0x40;
  - at t+2: all control outputs 0;
  - `br_count`=1, `taken_count`=1.
- **Not-taken BNE then JMP**: BNE with `br_taken`=0, then JMP with `br_taken`=1 and target 0x100 ->
  - no redirect for the BNE;
  - one redirect cycle after the JMP with `pc_target`=0x100;
  - counts 2/1.
- **Hazard then branch**: `hazard`=1 for 3 cycles with a taken branch in ID ->
  - 3 cycles of `pc_freeze`, `ifid_freeze` and `idex_bubble`, with counts unchanged;
  - evaluation on the 4th cycle, REDIRECT on the 5th.
- **Freeze in REDIRECT**: drop `mem_ready` during REDIRECT for 2 cycles ->
  - `pipe_freeze`=1 and `pc_src`=0 in those cycles;
  - REDIRECT outputs appear in the cycle `mem_ready` returns, then RUN;
  - `taken_count` increments only once.
- **Saturation**: with `CNT_W`=4, evaluate 20 taken branches spaced 3 cycles apart -> both counters stop at 15.

Source files
------------

// File: rtl/branch_flow_ctrl.sv
// Branch sequencing for the ID-stage resolver: gates evaluation against hazards
// and memory freezes, drives PC redirect / flush / bubble, keeps perf counters.
module branch_flow_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       br_type,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             hazard,
  input  logic             mem_ready,
  output logic             pc_src,
  output logic [31:0]      pc_target,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

  state_t state, state_nxt;
  logic   eval, take;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Evaluation only happens in an unfrozen, hazard-free RUN cycle.
  assign eval = !rst && mem_ready && (state == RUN) && !hazard && (br_type != 2'b00);
  assign take = eval && br_taken;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mem_ready) begin
      case (state)
        REDIRECT: state_nxt = RUN;
        default:  state_nxt = take ? REDIRECT : RUN;
      endcase
    end
  end

  always_comb begin
    pc_src      = 1'b0;
    pc_freeze   = 1'b0;
    ifid_freeze = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      // reset overrides everything, including the memory freeze
    end else if (!mem_ready) begin
      pc_freeze   = 1'b1;
      ifid_freeze = 1'b1;
      pipe_freeze = 1'b1;
    end else if (state == REDIRECT) begin
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_freeze   = 1'b1;
      ifid_freeze = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_target   <= '0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      if (take) pc_target <= br_target;
      if (eval && br_count != CNT_MAX)    br_count    <= br_count + CNT_W'(1);
      if (take && taken_count != CNT_MAX) taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule
